// File: rtl/hilo_mdu_if.sv
// Purpose: issue/result bundle between the EX stage and the HI/LO multiply-divide unit.
// Latency: wires only, no storage.
// Backpressure: none; the unit's busy output is the stall indication for hazard logic.
interface hilo_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       hiloOp;
  logic             cancel;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, hiloOp, cancel, rsData, rtData,
    input  busy, hi, lo
  );

  modport slave (
    input  start, hiloOp, cancel, rsData, rtData,
    output busy, hi, lo
  );
endinterface

// File: rtl/hilo_mdu.sv
// Purpose: HI/LO register pair with multi-cycle mult/multu/div/divu, mthi/mtlo, optional madd (HILO_MADD_EN).
// Latency: mthi/mtlo land on the issue edge; mul ops busy MUL_LAT cycles, div ops DIV_LAT cycles.
// Backpressure: busy=1 while an op runs; starts seen during busy are dropped, cancel aborts and keeps HI/LO.
module hilo_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  hilo_mdu_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] res_q;
  logic               keep_q;     // divide by zero: run the full period but leave HI/LO alone

  logic               is_mul, is_div, is_sdiv, mul_sgn, div_zero;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [2*WIDTH-1:0] res_d;

`ifdef HILO_MADD_EN
  logic               is_madd;
  logic               madd_q;
  logic [2*WIDTH-1:0] acc_d;
`endif

  // Decode the issued op and compute its full result up front; RUN only models latency.
  always_comb begin
    is_mul  = (bus.hiloOp == 3'b001) || (bus.hiloOp == 3'b010);
    is_div  = (bus.hiloOp == 3'b011) || (bus.hiloOp == 3'b100);
    is_sdiv = (bus.hiloOp == 3'b011);
    mul_sgn = (bus.hiloOp == 3'b001);
`ifdef HILO_MADD_EN
    is_madd = (bus.hiloOp == 3'b111);
    if (is_madd) begin
      is_mul  = 1'b1;
      mul_sgn = 1'b1;
    end
`endif
    a_ext = mul_sgn ? {{WIDTH{bus.rsData[WIDTH-1]}}, bus.rsData} : {{WIDTH{1'b0}}, bus.rsData};
    b_ext = mul_sgn ? {{WIDTH{bus.rtData[WIDTH-1]}}, bus.rtData} : {{WIDTH{1'b0}}, bus.rtData};
    prod  = a_ext * b_ext;

    // Signed divide on magnitudes so MIN/-1 wraps naturally to MIN with remainder 0.
    a_neg    = is_sdiv & bus.rsData[WIDTH-1];
    b_neg    = is_sdiv & bus.rtData[WIDTH-1];
    a_mag    = a_neg ? -bus.rsData : bus.rsData;
    b_mag    = b_neg ? -bus.rtData : bus.rtData;
    div_zero = is_div && (bus.rtData == '0);
    b_safe   = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;

    res_d = is_div ? {rem, quo} : prod;
  end

`ifdef HILO_MADD_EN
  // Accumulate against HI/LO as they stand at completion.
  always_comb begin
    acc_d = {hi_q, lo_q} + res_q;
  end
`endif

  // Control FSM with registered busy/HI/LO; cancel beats both start and completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      keep_q  <= 1'b0;
`ifdef HILO_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            if (is_mul || is_div) begin
              res_q   <= res_d;
              keep_q  <= div_zero;
              cnt_q   <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
              busy_q  <= 1'b1;
              state_q <= RUN;
`ifdef HILO_MADD_EN
              madd_q  <= is_madd;
`endif
            end else if (bus.hiloOp == 3'b101) begin
              hi_q <= bus.rsData;
            end else if (bus.hiloOp == 3'b110) begin
              lo_q <= bus.rsData;
            end
          end
        end
        RUN: begin
          if (bus.cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (!keep_q) begin
`ifdef HILO_MADD_EN
              {hi_q, lo_q} <= madd_q ? acc_d : res_q;
`else
              {hi_q, lo_q} <= res_q;
`endif
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Purpose: scoreboard bench for hilo_mdu; transaction-level HI/LO model with randomized op mix.
// Latency: each op is expected to hold busy for its full latency, or up to the cancel cycle.
// Backpressure: stimulus waits for busy to drop before the next op, except deliberate intrusions.
module tb_hilo_mdu;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hilo_mdu_if #(.WIDTH(W)) bus();

  hilo_mdu #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    int          blen;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          run_len = 0;
  logic        txn_done = 1'b0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO when the stimulus marks a transaction done.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      run_len = 0;
    end else if (txn_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        e = sb.pop_front();
        chk({e.name, " busy_len"}, 32'(run_len), 32'(e.blen));
        chk({e.name, " hi"}, bus.hi, e.hi);
        chk({e.name, " lo"}, bus.lo, e.lo);
      end
      run_len = 0;
    end else if (bus.busy) begin
      run_len++;
    end
  end

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return ML;
      3'd3, 3'd4: return DL;
`ifdef HILO_MADD_EN
      3'd7:       return ML;
`endif
      default:    return 0;
    endcase
  endfunction

  // Reference: architectural effect of one completed op, plain 64-bit arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      x, y, qv, rv;
    logic [63:0] p;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(x * y); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 0) begin qv = x / y; rv = x % y; m_lo = 32'(qv); m_hi = 32'(rv); end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
`ifdef HILO_MADD_EN
      3'd7: begin p = {m_hi, m_lo} + 64'(x * y); m_hi = p[63:32]; m_lo = p[31:0]; end
`endif
      default: ;
    endcase
  endtask

  // cancel_at: -1 never, 0 together with start, k>0 during busy cycle k.
  // inj_at: busy cycle in which a second start (inj_op) is attempted, -1 for none.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cancel_at, input int inj_at,
                        input logic [2:0] inj_op, input logic [31:0] inj_d);
    int   lat, blen, c;
    exp_t e;
    lat = lat_of(op);
    bus.start  = 1'b1;
    bus.hiloOp = op;
    bus.rsData = a;
    bus.rtData = b;
    bus.cancel = (cancel_at == 0);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.hiloOp = 3'd0;
    bus.cancel = 1'b0;
    bus.rsData = $urandom;
    bus.rtData = $urandom;
    if (cancel_at == 0) begin
      blen = 0;
    end else if (cancel_at > 0 && cancel_at <= lat) begin
      blen = cancel_at;
    end else begin
      blen = lat;
      model_apply(op, a, b);
    end
    e.name = nm; e.blen = blen; e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
    c = 1;
    while (bus.busy && c < 200) begin
      if (c == cancel_at) bus.cancel = 1'b1;
      if (c == inj_at) begin
        bus.start  = 1'b1;
        bus.hiloOp = inj_op;
        bus.rsData = inj_d;
      end
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      bus.start  = 1'b0;
      bus.hiloOp = 3'd0;
      c++;
    end
    if (c >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s busy_timeout actual=stuck expected=idle", nm);
    end
    txn_done = 1'b1;
    @(posedge clk); #1;
    txn_done = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          ca, ia;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.hiloOp = 3'd0;
    bus.cancel = 1'b0;
    bus.rsData = '0;
    bus.rtData = '0;
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg1x2",  3'd1, 32'hFFFF_FFFF, 32'h2, -1, -1, 3'd0, 0);
    run_op("multu_max_x2", 3'd2, 32'hFFFF_FFFF, 32'h2, -1, -1, 3'd0, 0);
    run_op("div_m7_2",     3'd3, 32'hFFFF_FFF9, 32'h2, -1, -1, 3'd0, 0);
    run_op("divu_by_zero", 3'd4, 32'h7,         32'h0, -1, -1, 3'd0, 0);
    run_op("mtlo",         3'd6, 32'h1234_5678, 32'h0, -1, -1, 3'd0, 0);
    run_op("mult_3x4_mthi_ignored", 3'd1, 32'd3, 32'd4, -1, 2, 3'd5, 32'hAAAA_0000);
    run_op("div_cancel_c4", 3'd3, 32'd100, 32'd7, 4, -1, 3'd0, 0);
    run_op("divu_cancel_last", 3'd4, 32'd100, 32'd7, DL, -1, 3'd0, 0);
    run_op("mthi_with_cancel", 3'd5, 32'hDEAD_BEEF, 32'h0, 0, -1, 3'd0, 0);
    run_op("div_min_m1",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 3'd0, 0);
    run_op("div_7_m2",     3'd3, 32'd7, 32'hFFFF_FFFE, -1, -1, 3'd0, 0);
    run_op("nop",          3'd0, 32'h5555_5555, 32'h1, -1, -1, 3'd0, 0);
    run_op("mthi_0",       3'd5, 32'h0, 32'h0, -1, -1, 3'd0, 0);
    run_op("mtlo_ffff",    3'd6, 32'hFFFF_FFFF, 32'h0, -1, -1, 3'd0, 0);
    run_op("op7_1x1",      3'd7, 32'h1, 32'h1, -1, -1, 3'd0, 0);

    // Asynchronous reset in the middle of a divide.
    bus.start = 1'b1; bus.hiloOp = 3'd4; bus.rsData = 32'd50; bus.rtData = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hiloOp = 3'd0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset busy", 32'(bus.busy), 32'd0);
    chk("async_reset hi", bus.hi, 32'd0);
    chk("async_reset lo", bus.lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      ca = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1;
      ia = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 10)) : -1;
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ca, ia,
             3'($urandom_range(1, 7)), $urandom);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
